// File: rtl/rr_mux_nx1.sv
// rr_mux_nx1: N-to-1 registered mux with manual or round-robin channel grant.
module rr_mux_nx1 #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_ch
);
    logic          load_en;
    logic          xfer;
    logic          grant_vld;
    logic [SW-1:0] grant;
    logic [SW-1:0] cand;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;

    assign load_en = !out_valid_q || out_ready;
    assign xfer = grant_vld && load_en && !rst;
    assign in_ready = xfer ? (N'(1) << grant) : '0;
    assign out_data = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ch = out_ch_q;

    // Pick the granted channel; the round-robin loop runs backwards so the nearest valid channel after ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant = '0;
        cand = '0;
        if (mode) begin
            for (int k = N; k >= 1; k--) begin
                cand = SW'((int'(ptr_q) + k) % N);
                if (in_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant = cand;
                end
            end
        end else if (int'(sel) < N) begin
            grant_vld = in_valid[sel];
            grant = sel;
        end
    end

    // Output register next state: load on transfer, otherwise drain when downstream accepts.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d = out_data_q;
        out_ch_d = out_ch_q;
        ptr_d = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d = in_data[int'(grant)*W +: W];
            out_ch_d = grant;
            ptr_d = grant;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; ptr resets to N-1 so the first round-robin search begins at channel 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_ch_q <= '0;
            ptr_q <= SW'(N - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            out_ch_q <= out_ch_d;
            ptr_q <= ptr_d;
        end
    end
endmodule
